dcache_data_banked_store: RTL and testbench

//  Multi-way, byte-enable data store for the write-through D-cache. It has a

---
 rtl/dcache_pkg.sv | 13 +
 rtl/dcache_data_way_sram.sv | 40 ++++
 rtl/dcache_data_banked_store.sv | 164 ++++++++++++++++
 tb/tb_dcache_data_banked_store.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared sizing constants and state type for the write-through D-cache data store.
package dcache_pkg;

    localparam int unsigned DCACHE_DATA_WIDTH = 32;
    localparam int unsigned DCACHE_NUM_WORDS  = 256;
    localparam int unsigned DCACHE_NUM_WAYS   = 4;

    typedef enum logic {
        INIT,
        READY
    } dcache_data_state_e;

endpackage

// File: rtl/dcache_data_way_sram.sv
// One cache way: simple-dual-port, byte-writable, 1-cycle-read block RAM.
// The array has no reset so that it maps onto FPGA block RAM.
module dcache_data_way_sram
    import dcache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DCACHE_DATA_WIDTH,
    parameter int unsigned NUM_WORDS  = DCACHE_NUM_WORDS,
    localparam int unsigned AW        = $clog2(NUM_WORDS),
    localparam int unsigned BW        = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [BW-1:0]         be_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Read returns the pre-write contents on an address clash; the top merges.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < int'(BW); i++) begin
                if (be_i[i]) begin
                    mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dcache_data_banked_store.sv
// Multi-way byte-enable data store with self-clearing init, handshakes and write-first bypass.
// Define DCACHE_DATA_OUTREG_EN to add an output register stage (read latency 2 instead of 1).
module dcache_data_banked_store
    import dcache_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DCACHE_DATA_WIDTH,
    parameter int unsigned NUM_WORDS  = DCACHE_NUM_WORDS,
    parameter int unsigned NUM_WAYS   = DCACHE_NUM_WAYS,
    localparam int unsigned AW        = $clog2(NUM_WORDS),
    localparam int unsigned WW        = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int unsigned BW        = DATA_WIDTH / 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    output logic                           init_done_o,
    input  logic                           rd_req_i,
    output logic                           rd_gnt_o,
    input  logic [AW-1:0]                  rd_addr_i,
    output logic                           rd_valid_o,
    output logic [NUM_WAYS*DATA_WIDTH-1:0] rdata_o,
    input  logic                           wr_req_i,
    output logic                           wr_gnt_o,
    input  logic [WW-1:0]                  wr_way_i,
    input  logic [AW-1:0]                  wr_addr_i,
    input  logic [BW-1:0]                  wr_be_i,
    input  logic [DATA_WIDTH-1:0]          wr_data_i
);

    dcache_data_state_e state_q, state_d;
    logic [AW-1:0]         cnt_q, cnt_d;
    logic                  ready;

    logic [NUM_WAYS-1:0]   sram_we;
    logic [AW-1:0]         sram_waddr;
    logic [BW-1:0]         sram_be;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] way_rdata [NUM_WAYS];
    logic [DATA_WIDTH-1:0] wr_mask;

    logic                  rd_valid_q, rd_valid_d;
    logic                  coll_q, coll_d;
    logic [WW-1:0]         coll_way_q, coll_way_d;
    logic [DATA_WIDTH-1:0] coll_mask_q, coll_mask_d;
    logic [DATA_WIDTH-1:0] coll_data_q, coll_data_d;
    logic [NUM_WAYS*DATA_WIDTH-1:0] merged;

    assign ready       = (state_q == READY);
    assign init_done_o = ready;
    assign rd_gnt_o    = ready & rd_req_i;
    assign wr_gnt_o    = ready & wr_req_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(NUM_WORDS - 1)) begin
                state_d = READY;
            end
        end
    end

    // During INIT the write port is borrowed to zero every way at index cnt_q.
    always_comb begin
        for (int i = 0; i < int'(BW); i++) begin
            wr_mask[i*8 +: 8] = {8{wr_be_i[i]}};
        end
        if (!ready) begin
            sram_we    = '1;
            sram_waddr = cnt_q;
            sram_be    = '1;
            sram_wdata = '0;
        end else begin
            for (int w = 0; w < int'(NUM_WAYS); w++) begin
                sram_we[w] = wr_gnt_o && (wr_way_i == WW'(w));
            end
            sram_waddr = wr_addr_i;
            sram_be    = wr_be_i;
            sram_wdata = wr_data_i;
        end
    end

    always_comb begin
        rd_valid_d  = rd_gnt_o;
        coll_d      = rd_gnt_o && wr_gnt_o && (rd_addr_i == wr_addr_i);
        coll_way_d  = wr_way_i;
        coll_mask_d = wr_mask;
        coll_data_d = wr_data_i & wr_mask;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            rd_valid_q  <= 1'b0;
            coll_q      <= 1'b0;
            coll_way_q  <= '0;
            coll_mask_q <= '0;
            coll_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_valid_q  <= rd_valid_d;
            coll_q      <= coll_d;
            coll_way_q  <= coll_way_d;
            coll_mask_q <= coll_mask_d;
            coll_data_q <= coll_data_d;
        end
    end

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        dcache_data_way_sram #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_WORDS  (NUM_WORDS)
        ) u_sram (
            .clk_i   (clk_i),
            .we_i    (sram_we[w]),
            .waddr_i (sram_waddr),
            .be_i    (sram_be),
            .wdata_i (sram_wdata),
            .re_i    (rd_gnt_o),
            .raddr_i (rd_addr_i),
            .rdata_o (way_rdata[w])
        );
    end

    // Write-first: overlay the bytes written in the grant cycle onto the old word.
    always_comb begin
        merged = '0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            merged[w*DATA_WIDTH +: DATA_WIDTH] = way_rdata[w];
            if (coll_q && (coll_way_q == WW'(w))) begin
                merged[w*DATA_WIDTH +: DATA_WIDTH] = (way_rdata[w] & ~coll_mask_q) | coll_data_q;
            end
        end
    end

`ifdef DCACHE_DATA_OUTREG_EN
    logic                           out_valid_q, out_valid_d;
    logic [NUM_WAYS*DATA_WIDTH-1:0] out_data_q, out_data_d;

    always_comb begin
        out_valid_d = rd_valid_q;
        out_data_d  = rd_valid_q ? merged : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign rd_valid_o = out_valid_q;
    assign rdata_o    = out_valid_q ? out_data_q : '0;
`else
    assign rd_valid_o = rd_valid_q;
    assign rdata_o    = rd_valid_q ? merged : '0;
`endif

endmodule

// File: tb/tb_dcache_data_banked_store.sv
// Bench for dcache_data_banked_store: vector table plus scoreboard of expected read data.
module tb_dcache_data_banked_store;

`ifdef DCACHE_DATA_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         init_done_o;
    logic         rd_req_i = 1'b0;
    logic         rd_gnt_o;
    logic [7:0]   rd_addr_i = '0;
    logic         rd_valid_o;
    logic [127:0] rdata_o;
    logic         wr_req_i = 1'b0;
    logic         wr_gnt_o;
    logic [1:0]   wr_way_i = '0;
    logic [7:0]   wr_addr_i = '0;
    logic [3:0]   wr_be_i = '0;
    logic [31:0]  wr_data_i = '0;

    always #5 clk = ~clk;

    dcache_data_banked_store #(
        .DATA_WIDTH (32),
        .NUM_WORDS  (256),
        .NUM_WAYS   (4)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .init_done_o (init_done_o),
        .rd_req_i    (rd_req_i),
        .rd_gnt_o    (rd_gnt_o),
        .rd_addr_i   (rd_addr_i),
        .rd_valid_o  (rd_valid_o),
        .rdata_o     (rdata_o),
        .wr_req_i    (wr_req_i),
        .wr_gnt_o    (wr_gnt_o),
        .wr_way_i    (wr_way_i),
        .wr_addr_i   (wr_addr_i),
        .wr_be_i     (wr_be_i),
        .wr_data_i   (wr_data_i)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  way;
        logic [7:0]  waddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rd;
        logic [7:0]  raddr;
        logic [1:0]  chk_way;
        logic [31:0] chk_word;
    } vec_t;

    typedef struct {
        int           due;
        logic [127:0] data;
        logic [1:0]   way;
        logic [31:0]  word;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    exp_t        sb[$];
    logic [31:0] mdl [4][256];
    vec_t        vecs [13];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_model();
        for (int w = 0; w < 4; w++) begin
            for (int a = 0; a < 256; a++) begin
                mdl[w][a] = '0;
            end
        end
    endtask

    function automatic logic [127:0] snapshot(input logic [7:0] a);
        return {mdl[3][a], mdl[2][a], mdl[1][a], mdl[0][a]};
    endfunction

    always @(negedge clk) begin
        if (rst_ni) begin
            if (rd_valid_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 128'(rd_valid_o), 128'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("read_latency", 128'(cyc), 128'(e.due));
                    chk("rdata_all_ways", rdata_o, e.data);
                    chk("rdata_way_word", 128'(rdata_o[e.way*32 +: 32]), 128'(e.word));
                end
            end else begin
                chk("rdata_zero_idle", rdata_o, 128'(0));
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    chk("missing_valid", 128'(rd_valid_o), 128'(1));
                    void'(sb.pop_front());
                end
            end
        end
    end

    // Drive one cycle at a negedge; the model applies the write before the
    // read snapshot so same-cycle collisions read write-first.
    task automatic drive(input vec_t v);
        @(negedge clk);
        wr_req_i  = v.wr;
        wr_way_i  = v.way;
        wr_addr_i = v.waddr;
        wr_be_i   = v.be;
        wr_data_i = v.wdata;
        rd_req_i  = v.rd;
        rd_addr_i = v.raddr;
        #1;
        chk("rd_gnt", 128'(rd_gnt_o), 128'(v.rd));
        chk("wr_gnt", 128'(wr_gnt_o), 128'(v.wr));
        if (v.wr) begin
            for (int i = 0; i < 4; i++) begin
                if (v.be[i]) mdl[v.way][v.waddr][i*8 +: 8] = v.wdata[i*8 +: 8];
            end
        end
        if (v.rd) begin
            exp_t e;
            e.due  = cyc + LAT;
            e.data = snapshot(v.raddr);
            e.way  = v.chk_way;
            e.word = v.chk_word;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        vec_t v;
        v = '{1'b0, 2'd0, 8'h00, 4'h0, 32'h0, 1'b0, 8'h00, 2'd0, 32'h0};
        drive(v);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 10) begin
            idle();
            n++;
        end
        chk("drain_timeout", 128'(sb.size()), 128'(0));
        idle();
    endtask

    task automatic wait_init();
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            chk("init_done", 128'(init_done_o), 128'(k == 256));
            if (k < 256) chk("init_rd_gnt", 128'(rd_gnt_o), 128'(0));
        end
        rd_req_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni   = 1'b0;
        wr_req_i = 1'b0;
        rd_req_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_init_done", 128'(init_done_o), 128'(0));
        chk("reset_rd_valid", 128'(rd_valid_o), 128'(0));
        sb.delete();
        clear_model();
        rst_ni = 1'b1;
        wait_init();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 2'd0, 8'h00, 4'b0000, 32'h0,        1'b1, 8'h80, 2'd0, 32'h0};
        vecs[1]  = '{1'b1, 2'd2, 8'h10, 4'b0101, 32'hDEADBEEF, 1'b1, 8'hFF, 2'd3, 32'h0};
        vecs[2]  = '{1'b0, 2'd0, 8'h00, 4'b0000, 32'h0,        1'b1, 8'h10, 2'd2, 32'h00AD00EF};
        vecs[3]  = '{1'b1, 2'd1, 8'h05, 4'b1111, 32'h11223344, 1'b1, 8'h05, 2'd1, 32'h11223344};
        vecs[4]  = '{1'b1, 2'd1, 8'h05, 4'b0010, 32'hAABBCCDD, 1'b1, 8'h05, 2'd1, 32'h1122CC44};
        vecs[5]  = '{1'b1, 2'd0, 8'h05, 4'b0000, 32'hFFFFFFFF, 1'b1, 8'h05, 2'd0, 32'h0};
        vecs[6]  = '{1'b1, 2'd3, 8'hFF, 4'b1000, 32'h12345678, 1'b1, 8'hFF, 2'd3, 32'h12000000};
        vecs[7]  = '{1'b1, 2'd0, 8'h00, 4'b1111, 32'hCAFEF00D, 1'b1, 8'h10, 2'd2, 32'h00AD00EF};
        vecs[8]  = '{1'b1, 2'd2, 8'h10, 4'b1111, 32'h01020304, 1'b1, 8'h11, 2'd2, 32'h0};
        vecs[9]  = '{1'b0, 2'd0, 8'h00, 4'b0000, 32'h0,        1'b1, 8'h10, 2'd2, 32'h01020304};
        vecs[10] = '{1'b0, 2'd0, 8'h00, 4'b0000, 32'h0,        1'b1, 8'h00, 2'd0, 32'hCAFEF00D};
        vecs[11] = '{1'b1, 2'd0, 8'h00, 4'b1111, 32'h0,        1'b1, 8'h00, 2'd0, 32'h0};
        vecs[12] = '{1'b0, 2'd0, 8'h00, 4'b0000, 32'h0,        1'b1, 8'h05, 2'd1, 32'h1122CC44};

        clear_model();
        @(negedge clk);
        chk("por_init_done", 128'(init_done_o), 128'(0));
        chk("por_rd_valid", 128'(rd_valid_o), 128'(0));
        chk("por_rdata", rdata_o, 128'(0));
        chk("por_wr_gnt", 128'(wr_gnt_o), 128'(0));
        do_reset();

        for (int i = 0; i < 13; i++) drive(vecs[i]);
        drain();

        // Back-to-back: distinct writes, then eight consecutive reads.
        for (int i = 0; i < 8; i++) begin
            vec_t v;
            v = '{1'b1, 2'(i % 4), 8'(i), 4'b1111, 32'hB0000000 | (32'(i) * 32'h00010101),
                  1'b0, 8'h00, 2'd0, 32'h0};
            drive(v);
        end
        for (int i = 0; i < 8; i++) begin
            vec_t v;
            v = '{1'b0, 2'd0, 8'h00, 4'b0000, 32'h0,
                  1'b1, 8'(i), 2'(i % 4), 32'hB0000000 | (32'(i) * 32'h00010101)};
            drive(v);
        end
        drain();

        // Reset with a read in flight.
        @(negedge clk);
        rd_req_i  = 1'b1;
        rd_addr_i = 8'h10;
        @(posedge clk);
        #1 rd_req_i = 1'b0;
        for (int k = 1; k < LAT; k++) @(posedge clk);
        #1;
        chk("inflight_valid", 128'(rd_valid_o), 128'(1));
        rst_ni = 1'b0;
        #1;
        chk("reset_drop_valid", 128'(rd_valid_o), 128'(0));
        chk("reset_drop_rdata", rdata_o, 128'(0));
        do_reset();

        begin
            vec_t v;
            v = '{1'b0, 2'd0, 8'h00, 4'b0000, 32'h0, 1'b1, 8'h10, 2'd2, 32'h0};
            drive(v);
            v = '{1'b0, 2'd0, 8'h00, 4'b0000, 32'h0, 1'b1, 8'h05, 2'd1, 32'h0};
            drive(v);
            v = '{1'b0, 2'd0, 8'h00, 4'b0000, 32'h0, 1'b1, 8'h03, 2'd3, 32'h0};
            drive(v);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
